// File: rtl/buf_drive_sequencer.sv
// Steps a thermometer-coded bank of parallel buffer legs toward a requested level, one leg per STEP_CYC cycles, to bound di/dt.
// Latency: first leg moves one edge after accept; LVL_READY is low while ramping or while FORCE_OFF is held.
module buf_drive_sequencer #(
  parameter int NSEG     = 4,
  parameter int STEP_CYC = 2,
  parameter int LW       = $clog2(NSEG + 1)
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [LW-1:0]   LVL,
  input  logic            LVL_VALID,
  output logic            LVL_READY,
  input  logic            FORCE_OFF,
  output logic [NSEG-1:0] EN,
  output logic [LW-1:0]   CUR,
  output logic            DONE,
  output logic            CLAMPED,
  output logic            ABORTED
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [LW-1:0]   NSEG_L = LW'(NSEG);
  localparam logic [7:0]      RELOAD = 8'(STEP_CYC - 1);
  localparam logic [NSEG-1:0] LEG0   = NSEG'(1);

  state_t          state_q, state_d;
  logic [NSEG-1:0] en_q, en_d;
  logic [LW-1:0]   cur_q, cur_d;
  logic [LW-1:0]   tgt_q, tgt_d;
  logic [7:0]      timer_q, timer_d;
  logic            rdy_q, rdy_d;
  logic            done_q, done_d;
  logic            clamped_q, clamped_d;
  logic            aborted_q, aborted_d;
  logic [LW-1:0]   lvl_sat;
  logic [LW-1:0]   cur_step;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    aborted_d = 1'b0;
    cur_step  = cur_q;
    lvl_sat   = (LVL > NSEG_L) ? NSEG_L : LVL;

    if (FORCE_OFF) begin
      state_d   = IDLE;
      en_d      = '0;
      cur_d     = '0;
      timer_d   = '0;
      aborted_d = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (LVL_VALID && rdy_q) begin
            clamped_d = (LVL > NSEG_L);
            tgt_d     = lvl_sat;
            timer_d   = '0;
            if (lvl_sat > cur_q)      state_d = RAMP_UP;
            else if (lvl_sat < cur_q) state_d = RAMP_DOWN;
            else                      done_d  = 1'b1;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (timer_q == 8'd0) begin
            timer_d = RELOAD;
            // Thermometer code: grow/shrink from the top so only one leg toggles.
            if (state_q == RAMP_UP) begin
              en_d     = (en_q << 1) | LEG0;
              cur_step = cur_q + 1'b1;
            end else begin
              en_d     = en_q >> 1;
              cur_step = cur_q - 1'b1;
            end
            cur_d = cur_step;
            if (cur_step == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rdy_d = (state_d == IDLE) && !FORCE_OFF;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= IDLE;
      en_q      <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      timer_q   <= '0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
      aborted_q <= aborted_d;
    end
  end

  assign EN        = en_q;
  assign CUR       = cur_q;
  assign LVL_READY = rdy_q;
  assign DONE      = done_q;
  assign CLAMPED   = clamped_q;
  assign ABORTED   = aborted_q;

endmodule

// File: tb/tb_buf_drive_sequencer.sv
// Bench for buf_drive_sequencer: a level-based reference model pushes the expected outputs of every cycle
// into a scoreboard queue; an independent monitor pops and compares on each falling edge.
module tb_buf_drive_sequencer;

  localparam int NSEG     = 4;
  localparam int STEP_CYC = 2;
  localparam int LW       = $clog2(NSEG + 1);

  logic            CLK = 1'b0;
  logic            RN;
  logic [LW-1:0]   LVL;
  logic            LVL_VALID;
  logic            LVL_READY;
  logic            FORCE_OFF;
  logic [NSEG-1:0] EN;
  logic [LW-1:0]   CUR;
  logic            DONE;
  logic            CLAMPED;
  logic            ABORTED;

  buf_drive_sequencer #(.NSEG(NSEG), .STEP_CYC(STEP_CYC)) dut (
    .CLK(CLK), .RN(RN), .LVL(LVL), .LVL_VALID(LVL_VALID), .LVL_READY(LVL_READY),
    .FORCE_OFF(FORCE_OFF), .EN(EN), .CUR(CUR), .DONE(DONE), .CLAMPED(CLAMPED), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int  cur;
    bit  rdy;
    bit  done;
    bit  clamp;
    bit  abort;
    int  edge_id;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: level as a function of elapsed edges since accept.
  int  m_cur, m_start, m_tgt, m_k, edge_no;
  bit  m_busy, m_up, m_rdy, m_done, m_clamp, m_abort, rn_now;

  function automatic logic [NSEG-1:0] therm(input int n);
    logic [NSEG-1:0] t;
    for (int i = 0; i < NSEG; i++) t[i] = (i < n);
    return t;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_busy = 0; m_rdy = 1;
    m_done = 0; m_clamp = 0; m_abort = 0;
  endtask

  task automatic model_edge();
    int steps, n, t;
    m_done = 0; m_clamp = 0; m_abort = 0;
    if (FORCE_OFF) begin
      m_abort = m_busy;
      m_cur   = 0;
      m_busy  = 0;
    end else if (m_busy) begin
      steps = 1 + (edge_no - m_k - 1) / STEP_CYC;
      n     = m_up ? (m_tgt - m_start) : (m_start - m_tgt);
      if (steps >= n) begin
        m_cur  = m_tgt;
        m_busy = 0;
        m_done = 1;
      end else begin
        m_cur = m_up ? (m_start + steps) : (m_start - steps);
      end
    end else if (LVL_VALID && m_rdy) begin
      t       = (int'(LVL) > NSEG) ? NSEG : int'(LVL);
      m_clamp = (int'(LVL) > NSEG);
      if (t == m_cur) begin
        m_done = 1;
      end else begin
        m_busy  = 1;
        m_up    = (t > m_cur);
        m_start = m_cur;
        m_tgt   = t;
        m_k     = edge_no;
      end
    end
    m_rdy = !m_busy && !FORCE_OFF;
  endtask

  // One clock: model the edge using the inputs in force, then drive the next cycle's inputs.
  task automatic tick(input bit rn_i, input bit f_i, input bit v_i, input int lvl_i);
    exp_t e;
    @(posedge CLK);
    edge_no++;
    if (rn_now) model_edge();
    #1;
    RN        = rn_i;
    rn_now    = rn_i;
    if (!rn_i) model_reset();
    FORCE_OFF = f_i;
    LVL_VALID = v_i;
    LVL       = LW'(lvl_i);
    e.cur = m_cur; e.rdy = m_rdy; e.done = m_done;
    e.clamp = m_clamp; e.abort = m_abort; e.edge_id = edge_no;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (EN !== therm(e.cur) || CUR !== LW'(e.cur) || LVL_READY !== e.rdy ||
            DONE !== e.done || CLAMPED !== e.clamp || ABORTED !== e.abort) begin
          fails++;
          $display("FAIL outputs@edge%0d: got EN=%b CUR=%0d RDY=%b DONE=%b CLAMPED=%b ABORTED=%b, want EN=%b CUR=%0d RDY=%b DONE=%b CLAMPED=%b ABORTED=%b",
                   e.edge_id, EN, CUR, LVL_READY, DONE, CLAMPED, ABORTED,
                   therm(e.cur), e.cur, e.rdy, e.done, e.clamp, e.abort);
        end
      end
    end
  end

  initial begin : stim
    edge_no   = 0;
    RN        = 1'b0;
    rn_now    = 1'b0;
    FORCE_OFF = 1'b0;
    LVL_VALID = 1'b1;
    LVL       = LW'(3);
    model_reset();

    // Reset held with a pending request, then release with nothing requested.
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 3);
    idle(2);
    // Ramp up to 3.
    tick(1, 0, 1, 3);
    idle(7);
    // Ramp down to 1 with an ignored request mid-ramp.
    tick(1, 0, 1, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 2);
    idle(4);
    // Clamped request, then same-level request.
    tick(1, 0, 1, 6);
    idle(8);
    tick(1, 0, 1, 4);
    idle(2);
    // Back to zero, then FORCE_OFF mid-ramp while a request is offered.
    tick(1, 0, 1, 0);
    idle(8);
    tick(1, 0, 1, 4);
    idle(2);
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 2);
    tick(1, 1, 1, 2);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 2);
    idle(5);
    // Asynchronous reset mid-ramp.
    tick(1, 0, 1, 4);
    idle(2);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 4);
    idle(3);

    // Random traffic including rare resets and forced shutdowns.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, (1 << LW) - 1));
    end
    idle(2);
    @(negedge CLK);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
